// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write-port control slice.
// DW/AW/NREGS size the data path and the architected register set.
// PC_IDX is the program-counter index, which the register file does not hold.
// wb_req_t is one write-port request and is shared with the hazard unit.
package rf_ctrl_pkg;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NREGS = 15;

  localparam logic [AW-1:0] PC_IDX    = AW'(15);
  localparam logic [AW-1:0] NREGS_IDX = AW'(NREGS);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for multi-cycle (B) destinations.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   set_en, set_dest    B op issued; mark set_dest pending
//   clr_en, clr_dest    B entry driven to the register file; clear clr_dest
//   src1/src2, *_use    decode read indices and their true-operand flags
//   hazard              combinational: a used operand is still pending
//   err                 sticky: issue to an index already pending and not clearing
module rf_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_dest,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_dest,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  input  logic          src1_use,
  input  logic          src2_use,
  output logic          hazard,
  output logic          err
);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  logic             set_ok;
  logic             clr_ok;
  logic             dup_issue;

  // Indices at or above NREGS (the PC) are never tracked.
  assign set_ok = set_en && (set_dest < NREGS_IDX);
  assign clr_ok = clr_en && (clr_dest < NREGS_IDX);

  // One-hot set/clear masks for this cycle.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_ok) set_vec[set_dest] = 1'b1;
    if (clr_ok) clr_vec[clr_dest] = 1'b1;
  end

  // Re-issuing to an index that is being cleared this cycle is legal.
  assign dup_issue = set_ok && pending[set_dest] && !clr_vec[set_dest];

  // Set is applied after clear so a same-cycle set on that index wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      err     <= 1'b0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      if (dup_issue) err <= 1'b1;
    end
  end

  assign hazard = (src1_use && (src1 < NREGS_IDX) && pending[src1]) ||
                  (src2_use && (src2 < NREGS_IDX) && pending[src2]);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file's single write port between the pipeline
// write-back (A, never stalled) and a multi-cycle unit (B, valid/ready).
// A always wins. B results go through a one-entry holding buffer and are
// written when A is idle.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   a_wb_en, a_dest, a_result     pipeline write-back request
//   b_issue, b_issue_dest         B op launched (scoreboard set)
//   b_valid, b_dest, b_result     B result offered
//   b_ready                       holding buffer can accept a B result
//   src1/src2, src1_use/src2_use  decode operands for the hazard check
//   hazard                        decode must stall on a pending B operand
//   rf_we, rf_dest, rf_data       registered register-file write port
//   err                           sticky double-issue error
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          a_wb_en,
  input  logic [AW-1:0] a_dest,
  input  logic [DW-1:0] a_result,
  input  logic          b_issue,
  input  logic [AW-1:0] b_issue_dest,
  input  logic          b_valid,
  input  logic [AW-1:0] b_dest,
  input  logic [DW-1:0] b_result,
  output logic          b_ready,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  input  logic          src1_use,
  input  logic          src2_use,
  output logic          hazard,
  output logic          rf_we,
  output logic [AW-1:0] rf_dest,
  output logic [DW-1:0] rf_data,
  output logic          err
);

  // The holding buffer's we field doubles as its full flag.
  wb_req_t hold_q;
  wb_req_t sel_req;
  logic    sel_b;
  logic    b_take;

  // The buffer can refill in the cycle it drains, so it only blocks B
  // while it is full and A is holding the port.
  assign b_ready = !hold_q.we || !a_wb_en;
  assign b_take  = b_valid && b_ready;
  assign sel_b   = !a_wb_en && hold_q.we;

  // Port select: A first, then the buffered B entry, otherwise idle with
  // dest/data held.
  always_comb begin
    sel_req = '{we: 1'b0, dest: rf_dest, data: rf_data};
    if (a_wb_en) begin
      sel_req = '{we: 1'b1, dest: a_dest, data: a_result};
    end else if (hold_q.we) begin
      sel_req = hold_q;
    end
  end

  // Output registers and holding buffer. A PC-destined request is consumed
  // like any other but never asserts the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_dest <= '0;
      rf_data <= '0;
      hold_q  <= '0;
    end else begin
      rf_we   <= sel_req.we && (sel_req.dest != PC_IDX);
      rf_dest <= sel_req.dest;
      rf_data <= sel_req.data;
      if (b_take) begin
        hold_q <= '{we: 1'b1, dest: b_dest, data: b_result};
      end else if (sel_b) begin
        hold_q.we <= 1'b0;
      end
    end
  end

  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (b_issue),
    .set_dest (b_issue_dest),
    .clr_en   (sel_b),
    .clr_dest (hold_q.dest),
    .src1     (src1),
    .src2     (src2),
    .src1_use (src1_use),
    .src2_use (src2_use),
    .hazard   (hazard),
    .err      (err)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
  import rf_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_wb_en;
  logic [AW-1:0] a_dest;
  logic [DW-1:0] a_result;
  logic          b_issue;
  logic [AW-1:0] b_issue_dest;
  logic          b_valid;
  logic [AW-1:0] b_dest;
  logic [DW-1:0] b_result;
  logic          b_ready;
  logic [AW-1:0] src1;
  logic [AW-1:0] src2;
  logic          src1_use;
  logic          src2_use;
  logic          hazard;
  logic          rf_we;
  logic [AW-1:0] rf_dest;
  logic [DW-1:0] rf_data;
  logic          err;

  int checks   = 0;
  int failures = 0;

  rf_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .a_wb_en      (a_wb_en),
    .a_dest       (a_dest),
    .a_result     (a_result),
    .b_issue      (b_issue),
    .b_issue_dest (b_issue_dest),
    .b_valid      (b_valid),
    .b_dest       (b_dest),
    .b_result     (b_result),
    .b_ready      (b_ready),
    .src1         (src1),
    .src2         (src2),
    .src1_use     (src1_use),
    .src2_use     (src2_use),
    .hazard       (hazard),
    .rf_we        (rf_we),
    .rf_dest      (rf_dest),
    .rf_data      (rf_data),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs set beforehand are sampled at the edge and
  // outputs are read 1ns later.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    a_wb_en = 0; a_dest = 0; a_result = 0;
    b_issue = 0; b_issue_dest = 0;
    b_valid = 0; b_dest = 0; b_result = 0;
    src1 = 0; src2 = 0; src1_use = 0; src2_use = 0;
  endtask

  task automatic pulseReset();
    rst = 1;
    applyStimulus();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clearInputs();
    applyStimulus();
    applyStimulus();
    rst = 0;
    #1;

    $display("[TB] reset state");
    checkOutput("rst_rf_we", rf_we, 0);
    checkOutput("rst_rf_dest", rf_dest, 0);
    checkOutput("rst_rf_data", rf_data, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_b_ready", b_ready, 1);
    checkOutput("rst_hazard", hazard, 0);

    $display("[TB] A only");
    a_wb_en = 1; a_dest = 3; a_result = 32'h55;
    #1 checkOutput("a_b_ready", b_ready, 1);
    applyStimulus();
    checkOutput("a_rf_we", rf_we, 1);
    checkOutput("a_rf_dest", rf_dest, 3);
    checkOutput("a_rf_data", rf_data, 32'h55);
    a_wb_en = 0;
    applyStimulus();
    checkOutput("a_idle_we", rf_we, 0);
    checkOutput("a_idle_data_hold", rf_data, 32'h55);

    $display("[TB] contention");
    a_wb_en = 1; a_dest = 1; a_result = 32'h11;
    b_valid = 1; b_dest = 5; b_result = 32'hAA;
    #1 checkOutput("ct_c0_b_ready", b_ready, 1);
    applyStimulus();
    b_valid = 0;
    a_dest = 2; a_result = 32'h22;
    #1 checkOutput("ct_c1_b_ready", b_ready, 0);
    checkOutput("ct_c1_rf_dest", rf_dest, 1);
    applyStimulus();
    a_dest = 3; a_result = 32'h33;
    #1 checkOutput("ct_c2_b_ready", b_ready, 0);
    checkOutput("ct_c2_rf_dest", rf_dest, 2);
    applyStimulus();
    a_wb_en = 0;
    #1 checkOutput("ct_c3_b_ready", b_ready, 1);
    checkOutput("ct_c3_rf_dest", rf_dest, 3);
    applyStimulus();
    checkOutput("ct_b_we", rf_we, 1);
    checkOutput("ct_b_dest", rf_dest, 5);
    checkOutput("ct_b_data", rf_data, 32'hAA);
    applyStimulus();
    checkOutput("ct_after_we", rf_we, 0);

    $display("[TB] scoreboard");
    b_issue = 1; b_issue_dest = 7;
    src1 = 7; src1_use = 1;
    #1 checkOutput("sb_pre_hazard", hazard, 0);
    applyStimulus();
    b_issue = 0;
    #1 checkOutput("sb_hazard_set", hazard, 1);
    src1_use = 0;
    #1 checkOutput("sb_nouse_hazard", hazard, 0);
    src2 = 7; src2_use = 1;
    #1 checkOutput("sb_src2_hazard", hazard, 1);
    src2_use = 0; src1_use = 1;
    b_valid = 1; b_dest = 7; b_result = 32'h77;
    applyStimulus();
    b_valid = 0;
    checkOutput("sb_nobypass_we", rf_we, 0);
    checkOutput("sb_buffered_hazard", hazard, 1);
    applyStimulus();
    checkOutput("sb_b_we", rf_we, 1);
    checkOutput("sb_b_dest", rf_dest, 7);
    checkOutput("sb_b_data", rf_data, 32'h77);
    checkOutput("sb_hazard_clear", hazard, 0);
    b_issue = 1; b_issue_dest = 15;
    src1 = 15;
    applyStimulus();
    b_issue = 0;
    checkOutput("sb_pc_hazard", hazard, 0);
    checkOutput("sb_pc_err", err, 0);
    src1_use = 0;

    $display("[TB] dest 15");
    a_wb_en = 1; a_dest = 15; a_result = 32'h99;
    applyStimulus();
    checkOutput("pc_a_we", rf_we, 0);
    a_wb_en = 0;
    b_valid = 1; b_dest = 15; b_result = 32'h1234;
    applyStimulus();
    b_valid = 0;
    applyStimulus();
    checkOutput("pc_b_we", rf_we, 0);
    a_wb_en = 1;
    #1 checkOutput("pc_b_drained", b_ready, 1);
    a_wb_en = 0;

    $display("[TB] double issue");
    b_issue = 1; b_issue_dest = 2;
    applyStimulus();
    checkOutput("dbl_first_err", err, 0);
    applyStimulus();
    b_issue = 0;
    checkOutput("dbl_err_set", err, 1);
    b_valid = 1; b_dest = 2; b_result = 32'h22;
    applyStimulus();
    b_valid = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("dbl_err_sticky", err, 1);
    pulseReset();
    #1 checkOutput("dbl_err_rst", err, 0);
    b_issue = 1; b_issue_dest = 2;
    applyStimulus();
    b_issue = 0;
    b_valid = 1; b_dest = 2; b_result = 32'h2222;
    applyStimulus();
    b_valid = 0;
    b_issue = 1; b_issue_dest = 2;
    src1 = 2; src1_use = 1;
    applyStimulus();
    b_issue = 0;
    checkOutput("sim_rf_dest", rf_dest, 2);
    checkOutput("sim_rf_we", rf_we, 1);
    checkOutput("sim_err", err, 0);
    checkOutput("sim_pending", hazard, 1);
    src1_use = 0;

    $display("[TB] reset mid-operation");
    pulseReset();
    b_issue = 1; b_issue_dest = 4;
    applyStimulus();
    a_wb_en = 1; a_dest = 6; a_result = 32'h66;
    b_valid = 1; b_dest = 4; b_result = 32'h44;
    applyStimulus();
    b_valid = 0;
    src1 = 4; src1_use = 1;
    #1 checkOutput("mid_b_ready", b_ready, 0);
    checkOutput("mid_hazard", hazard, 1);
    applyStimulus();
    b_issue = 0;
    checkOutput("mid_err", err, 1);
    pulseReset();
    a_wb_en = 0;
    #1 checkOutput("mid_rst_we", rf_we, 0);
    checkOutput("mid_rst_b_ready", b_ready, 1);
    checkOutput("mid_rst_hazard", hazard, 0);
    checkOutput("mid_rst_err", err, 0);
    applyStimulus();
    checkOutput("mid_rst_dropped", rf_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
